// File: rtl/core_pkg.sv
// Shared core constants for the pipeline stage registers, plus the skid
// buffer state encoding.
package core_pkg;

  localparam int unsigned CORE_XLEN       = 32;
  localparam int unsigned CORE_REG_ADDR_W = 5;

  localparam logic [CORE_XLEN-1:0]       DATA_ZERO = '0;
  localparam logic [CORE_REG_ADDR_W-1:0] ADDR_ZERO = '0;

  // Payload layout: {reg_data, mem_data, memtoreg, regwrite, rd}
  localparam int unsigned STAGE_PAYLOAD_W = 2*CORE_XLEN + 2 + CORE_REG_ADDR_W;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_e;

  function automatic int unsigned stage_payload_w(input int unsigned xlen,
                                                  input int unsigned addr_w);
    return 2*xlen + 2 + addr_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage buffer with synchronous flush. SKID=1 gives a
// 2-entry skid with registered ready_o; SKID=0 a single register.
module pipe_skid_buf
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = STAGE_PAYLOAD_W,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic             w_in;
  logic             w_out;
  logic             w_load_m_in;
  logic             w_load_m_s;
  logic             w_load_s;

  assign w_in  = valid_i & ready_o;
  assign w_out = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SB_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // With SKID=0 an input transfer in ONE implies ready_i, so FULL is unreachable.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = SB_EMPTY;
    end else begin
      unique case (r_state)
        SB_EMPTY: if (w_in) w_state_nxt = SB_ONE;
        SB_ONE: begin
          if (w_in && !w_out)      w_state_nxt = SB_FULL;
          else if (!w_in && w_out) w_state_nxt = SB_EMPTY;
        end
        SB_FULL:  if (w_out) w_state_nxt = SB_ONE;
        default:  w_state_nxt = SB_EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o     = (r_state != SB_EMPTY);
    ready_o     = (SKID != 0) ? (r_state != SB_FULL)
                              : (ready_i | (r_state == SB_EMPTY));
    occupancy_o = 2'd0;
    unique case (r_state)
      SB_ONE:  occupancy_o = 2'd1;
      SB_FULL: occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
    w_load_m_in = !flush_i & w_in &
                  ((r_state == SB_EMPTY) | ((r_state == SB_ONE) & w_out));
    w_load_s    = !flush_i & w_in & (r_state == SB_ONE) & !w_out;
    w_load_m_s  = !flush_i & (r_state == SB_FULL) & w_out;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_load_m_in)     r_m <= data_i;
      else if (w_load_m_s) r_m <= r_s;
      if (w_load_s)        r_s <= data_i;
    end
  end

  assign data_o = r_m;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB stage register: handshaked payload hold, x0 write suppression and
// pre-muxed writeback data.
module mem_wb_skid
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = CORE_XLEN,
  parameter int unsigned REG_ADDR_W = CORE_REG_ADDR_W,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       reg_data_i,
  input  logic [XLEN-1:0]       mem_data_i,
  input  logic                  memtoreg_i,
  input  logic                  regwrite_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       reg_data_o,
  output logic [XLEN-1:0]       mem_data_o,
  output logic                  memtoreg_o,
  output logic                  regwrite_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  wb_we_o,
  output logic [1:0]            occupancy_o
);

  localparam int unsigned PW = stage_payload_w(XLEN, REG_ADDR_W);

  logic [PW-1:0] w_pay_in;
  logic [PW-1:0] w_pay_out;
  logic          w_regwrite;

  assign w_regwrite = regwrite_i & (rd_i != '0);
  assign w_pay_in   = {reg_data_i, mem_data_i, memtoreg_i, w_regwrite, rd_i};

  pipe_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (w_pay_in),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (w_pay_out),
    .occupancy_o (occupancy_o)
  );

  assign {reg_data_o, mem_data_o, memtoreg_o, regwrite_o, rd_o} = w_pay_out;

  assign wb_data_o = memtoreg_o ? mem_data_o : reg_data_o;
  assign wb_we_o   = valid_o & regwrite_o;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: SKID=1 instance for most scenarios, SKID=0
// instance for the combinational-ready throughput case.
module tb_mem_wb_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        flush, vi, ri, m2r, rw;
  logic [31:0] rdat, mdat;
  logic [4:0]  rd;
  logic        ro, vo, m2r_o, rw_o, we_o;
  logic [31:0] rdat_o, mdat_o, wb_o;
  logic [4:0]  rd_o;
  logic [1:0]  occ;

  logic        vi0, ri0;
  logic [31:0] rdat0;
  logic [4:0]  rd0;
  logic        ro0, vo0, m2r_o0, rw_o0, we_o0;
  logic [31:0] rdat_o0, mdat_o0, wb_o0;
  logic [4:0]  rd_o0;
  logic [1:0]  occ0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_wb_skid #(.XLEN(32), .REG_ADDR_W(5), .SKID(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(vi), .ready_o(ro),
    .reg_data_i(rdat), .mem_data_i(mdat), .memtoreg_i(m2r),
    .regwrite_i(rw), .rd_i(rd),
    .valid_o(vo), .ready_i(ri),
    .reg_data_o(rdat_o), .mem_data_o(mdat_o), .memtoreg_o(m2r_o),
    .regwrite_o(rw_o), .rd_o(rd_o),
    .wb_data_o(wb_o), .wb_we_o(we_o), .occupancy_o(occ)
  );

  mem_wb_skid #(.XLEN(32), .REG_ADDR_W(5), .SKID(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .valid_i(vi0), .ready_o(ro0),
    .reg_data_i(rdat0), .mem_data_i(32'h0), .memtoreg_i(1'b0),
    .regwrite_i(1'b1), .rd_i(rd0),
    .valid_o(vo0), .ready_i(ri0),
    .reg_data_o(rdat_o0), .mem_data_o(mdat_o0), .memtoreg_o(m2r_o0),
    .regwrite_o(rw_o0), .rd_o(rd_o0),
    .wb_data_o(wb_o0), .wb_we_o(we_o0), .occupancy_o(occ0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic offer(input logic v, input logic [4:0] d_rd, input logic [31:0] d_reg,
                       input logic [31:0] d_mem, input logic d_m2r, input logic d_rw);
    vi = v; rd = d_rd; rdat = d_reg; mdat = d_mem; m2r = d_m2r; rw = d_rw;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ev;
    logic [31:0] ed;
    int          idx;
    int          outs;

    rst_n = 1'b0; flush = 1'b0; ri = 1'b0;
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    vi0 = 1'b0; ri0 = 1'b0; rdat0 = '0; rd0 = '0;

    #2;
    check("rst_valid", vo, 0);
    check("rst_ready", ro, 1);
    check("rst_occ", occ, 0);
    check("rst_wb_data", wb_o, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    check("post_rst_ready", ro, 1);
    check("post_rst_valid", vo, 0);

    // Streaming, full throughput
    ri = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      offer(1'b1, 5'(n), 32'h100 + 32'(n), 32'h0, 1'b0, 1'b1);
      check("stream_ready", ro, 1);
      tick;
      check("stream_valid", vo, 1);
      check("stream_wb_data", wb_o, 32'h100 + 32'(n));
      check("stream_rd", rd_o, 5'(n));
      check("stream_we", we_o, 1);
      check("stream_occ", occ, 1);
    end
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    check("stream_drain_valid", vo, 0);
    check("stream_drain_occ", occ, 0);

    // Back-pressure
    ri = 1'b0;
    offer(1'b1, 5'd9, 32'h200, 32'h0, 1'b0, 1'b1);
    tick;
    check("bp_occ1", occ, 1);
    check("bp_ready1", ro, 1);
    offer(1'b1, 5'd10, 32'h201, 32'h0, 1'b0, 1'b1);
    tick;
    check("bp_occ2", occ, 2);
    check("bp_ready_full", ro, 0);
    check("bp_head", wb_o, 32'h200);
    offer(1'b1, 5'd11, 32'h202, 32'h0, 1'b0, 1'b1);
    tick;
    check("bp_hold_occ", occ, 2);
    check("bp_hold_ready", ro, 0);
    check("bp_hold_data", wb_o, 32'h200);
    check("bp_hold_rd", rd_o, 9);
    ri = 1'b1;
    tick;
    check("bp_out2_data", wb_o, 32'h201);
    check("bp_out2_occ", occ, 1);
    check("bp_out2_ready", ro, 1);
    tick;
    check("bp_out3_data", wb_o, 32'h202);
    check("bp_out3_valid", vo, 1);
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    check("bp_drain_valid", vo, 0);

    // x0 suppression and writeback mux
    offer(1'b1, 5'd0, 32'h55, 32'h66, 1'b0, 1'b1);
    tick;
    check("x0_valid", vo, 1);
    check("x0_regwrite", rw_o, 0);
    check("x0_we", we_o, 0);
    check("x0_wb_data", wb_o, 32'h55);
    offer(1'b1, 5'd5, 32'h77, 32'hDEADBEEF, 1'b1, 1'b1);
    tick;
    check("mux_wb_data", wb_o, 32'hDEADBEEF);
    check("mux_we", we_o, 1);
    check("mux_reg_data", rdat_o, 32'h77);
    check("mux_rd", rd_o, 5);
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick;

    // Flush from FULL with a new entry offered
    ri = 1'b0;
    offer(1'b1, 5'd12, 32'h300, 32'h0, 1'b0, 1'b1);
    tick;
    offer(1'b1, 5'd13, 32'h301, 32'h0, 1'b0, 1'b1);
    tick;
    check("fl_pre_occ", occ, 2);
    offer(1'b1, 5'd14, 32'h302, 32'h0, 1'b0, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fl_valid", vo, 0);
    check("fl_occ", occ, 0);
    check("fl_ready", ro, 1);
    check("fl_we", we_o, 0);
    ri = 1'b1;
    tick;
    check("fl_gone1", vo, 0);
    tick;
    check("fl_gone2", vo, 0);

    // Flush discards an accepted input in ONE
    ri = 1'b0;
    offer(1'b1, 5'd15, 32'h310, 32'h0, 1'b0, 1'b1);
    tick;
    offer(1'b1, 5'd16, 32'h311, 32'h0, 1'b0, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fl1_valid", vo, 0);
    check("fl1_occ", occ, 0);

    // SKID=0: combinational ready, alternating downstream ready
    ev = 1'b0; ed = '0; idx = 0; outs = 0;
    for (int t = 0; t < 9; t++) begin
      ri0 = (t % 2 == 0);
      vi0 = 1'b1;
      rdat0 = 32'h400 + 32'(idx);
      rd0 = 5'(idx + 1);
      #1;
      check("s0_ready", ro0, ri0 | !ev);
      check("s0_valid", vo0, ev);
      if (ev) check("s0_data", wb_o0, ed);
      if (vo0 && ri0) begin
        check("s0_order", wb_o0, 32'h400 + 32'(outs));
        outs++;
      end
      if (ri0 || !ev) begin
        ev = 1'b1;
        ed = 32'h400 + 32'(idx);
        idx++;
      end else if (ev && ri0) begin
        ev = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    vi0 = 1'b0;
    check("s0_throughput", outs, 4);

    // Asynchronous reset mid-cycle with two entries held
    ri = 1'b0;
    offer(1'b1, 5'd20, 32'h500, 32'h0, 1'b0, 1'b1);
    tick;
    offer(1'b1, 5'd21, 32'h501, 32'h0, 1'b0, 1'b1);
    tick;
    offer(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("ar_pre_occ", occ, 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", vo, 0);
    check("ar_occ", occ, 0);
    check("ar_wb_data", wb_o, 0);
    check("ar_rd", rd_o, 0);
    check("ar_ready", ro, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("ar_post_ready", ro, 1);
    check("ar_post_valid", vo, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
Parametrised MEM/WB pipeline stage register with a valid/ready handshake, replacing the fixed always-advance stage register. An optional 2-entry skid buffer lets MEM keep issuing for one cycle while WB or the register file back-pressures. The block adds synchronous flush, suppression of writes to x0, and a pre-muxed writeback/forwarding result. It sits between the MEM stage (upstream) and the WB stage/register file (downstream).

Parameters:
XLEN, 32, register/data width in bits
REG_ADDR_W, 5, destination register index width
SKID, 1, 1 = 2-entry skid buffer (registered ready_o); 0 = single register (combinational ready_o)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; drops all held and incoming entries
valid_i  in  1  upstream entry valid
ready_o  out  1  stage can accept an entry this cycle
reg_data_i  in  XLEN  ALU/address result
mem_data_i  in  XLEN  load data
memtoreg_i  in  1  select mem_data for writeback
regwrite_i  in  1  entry writes the register file
rd_i  in  REG_ADDR_W  destination register
valid_o  out  1  downstream entry valid
ready_i  in  1  downstream accepts the entry
reg_data_o  out  XLEN  held ALU result
mem_data_o  out  XLEN  held load data
memtoreg_o  out  1  held select
regwrite_o  out  1  held write enable, already x0-suppressed
rd_o  out  REG_ADDR_W  held destination
wb_data_o  out  XLEN  memtoreg_o ? mem_data_o : reg_data_o (combinational)
wb_we_o  out  1  valid_o & regwrite_o (combinational)
occupancy_o  out  2  number of entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: valid_o=0, occupancy_o=0, all payload outputs=0. ready_o=1 while in reset and on the first cycle after reset.
- Handshake: input transfer = valid_i & ready_o. Output transfer = valid_o & ready_i.
- Handshake rules: upstream holds payload stable while valid_i & !ready_o. Entries leave in arrival order; none dropped or duplicated except by flush or reset.
- Capture rule: regwrite is captured as regwrite_i & (rd_i != 0). All other fields are captured verbatim.
- Latency: 1 cycle from an input transfer to valid_o when the stage is empty.
- SKID=1 states: main register M (drives the outputs) and skid register S; ready_o = !S.valid, registered.
  - EMPTY (0 entries): input transfer -> ONE, loads M.
  - ONE, out & !in -> EMPTY.
  - ONE, in & out -> ONE; M reloads from the input.
  - ONE, in & !out -> FULL; input goes to S.
  - ONE, neither -> ONE.
  - FULL: ready_o=0. Out transfer -> ONE, M <= S. No out transfer -> hold.
- SKID=0: ready_o = ready_i | !valid_o (combinational). M loads on every input transfer. valid_o clears on an out transfer with no in transfer.
- Full-throughput requirement: one transfer per cycle when valid_i=ready_i=1 continuously, in both modes.
- Flush: on a cycle with flush_i=1, both valids clear at the next edge and any input transfer that cycle is discarded. Flush dominates all simultaneous events.
  - Downstream may still consume valid_o in the flush cycle; WB commits that entry.
  - Payload registers are not cleared by flush. wb_we_o is 0 because valid_o=0.
  - State after flush = EMPTY, ready_o=1.
- Reset mid-operation: immediate clear of state and outputs, independent of the clock. No partial entry survives.
- Output stability: payload outputs change only on M load, flush-independent. With valid_o & !ready_i the payload holds stable.
- occupancy_o: registered; equals M.valid + S.valid.

Decomposition:
- Shared core_pkg holds XLEN, REG_ADDR_W, zero-data/zero-address constants and the stage payload width: 2*XLEN + 2 + REG_ADDR_W.
- One natural sub-module: pipe_skid_buf. It is generic, with parameters WIDTH and SKID, and implements the valid/ready/flush/occupancy logic on a flat payload vector.
- mem_wb_skid packs and unpacks the payload, applies x0 suppression, and forms wb_data_o and wb_we_o.

Test Plan:
- Reset: rst_ni=0 asynchronously mid-cycle with 2 entries held -> valid_o=0, occupancy_o=0, payload outputs=0 immediately; ready_o=1 after release.
- Streaming: 8 back-to-back entries, ready_i=1, rd=1..8, reg_data=0x100+n -> valid_o from cycle 1, one entry per cycle in order, wb_data_o=0x101..0x108.
- Back-pressure (SKID=1): ready_i=0 while 3 entries are offered.
  - After 2 accepts: occupancy_o=2, ready_o=0, third entry held upstream.
  - ready_i=1 -> all 3 delivered in order, no loss.
- x0 and mux: rd_i=0, regwrite_i=1 -> regwrite_o=0, wb_we_o=0. Then memtoreg_i=1, mem_data_i=0xDEADBEEF, rd=5 -> wb_data_o=0xDEADBEEF, wb_we_o=1.
- Flush: FULL state plus a new valid_i, with flush_i=1 for 1 cycle -> next cycle valid_o=0, occupancy_o=0, ready_o=1; the flushed entries never appear.
- SKID=0 build: ready_i toggling 1/0 each cycle with continuous valid_i -> ready_o follows ready_i | !valid_o combinationally, in-order delivery, 50% throughput.
